// File: rtl/datapath_seq.sv
// datapath_seq: self-sequenced A/B -> ALU -> C/S datapath with a bit-serial shifter and start/busy/done handshake.
// Optional rotate-mode shifting is enabled by defining DATAPATH_ROTATE_EN.
module datapath_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clock_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] din_a_i,
  input  logic [WIDTH-1:0] din_b_i,
  input  logic [CNT_W-1:0] shift_amt_i,
  input  logic             shift_dir_i,
  input  logic             shift_rot_i,
  input  logic             out_sel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] reg_a_o,
  output logic [WIDTH-1:0] reg_b_o,
  output logic [WIDTH-1:0] reg_c_o,
  output logic             zero_o,
  output logic             carry_o
);
  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic dir_q, dir_d, rot_q, rot_d, zero_q, zero_d, carry_q, carry_d, rot_in;
  logic [WIDTH:0] add, sub, inc;
  logic [WIDTH-1:0] alu, shl, shr;
  logic alu_c;
`ifdef DATAPATH_ROTATE_EN
  assign rot_in = shift_rot_i;
`else
  logic unused_rot;
  assign unused_rot = shift_rot_i;
  assign rot_in = 1'b0;
`endif
  assign add = {1'b0, a_q} + {1'b0, b_q};
  assign sub = {1'b0, a_q} - {1'b0, b_q};
  assign inc = {1'b0, a_q} + {{WIDTH{1'b0}}, 1'b1};
  always_comb begin
    alu = op_q == 3'd0 ? add[WIDTH-1:0] :
          op_q == 3'd1 ? sub[WIDTH-1:0] :
          op_q == 3'd2 ? a_q & b_q :
          op_q == 3'd3 ? a_q | b_q :
          op_q == 3'd4 ? a_q ^ b_q :
          op_q == 3'd5 ? ~a_q :
          op_q == 3'd6 ? inc[WIDTH-1:0] : b_q;
    alu_c = op_q == 3'd0 ? add[WIDTH] :
            op_q == 3'd1 ? sub[WIDTH] :
            op_q == 3'd6 ? inc[WIDTH] : 1'b0;
  end
  // rot_q gates the wrap-around bit; zero fill otherwise
  assign shl = {s_q[WIDTH-2:0], rot_q & s_q[WIDTH-1]};
  assign shr = {rot_q & s_q[0], s_q[WIDTH-1:1]};
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    s_d = s_q;
    cnt_d = cnt_q;
    op_d = op_q;
    dir_d = dir_q;
    rot_d = rot_q;
    zero_d = zero_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: if (start_i) begin
        a_d = din_a_i;
        b_d = din_b_i;
        op_d = op_i;
        cnt_d = shift_amt_i;
        dir_d = shift_dir_i;
        rot_d = rot_in;
        state_d = EXEC;
      end
      EXEC: begin
        c_d = alu;
        s_d = alu;
        zero_d = alu == '0;
        carry_d = alu_c;
        state_d = cnt_q != '0 ? SHIFT : DONE;
      end
      SHIFT: begin
        s_d = dir_q ? shr : shl;
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q == {{(CNT_W-1){1'b0}}, 1'b1} ? DONE : SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      s_q <= '0;
      cnt_q <= '0;
      op_q <= '0;
      dir_q <= 1'b0;
      rot_q <= 1'b0;
      zero_q <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      s_q <= s_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      dir_q <= dir_d;
      rot_q <= rot_d;
      zero_q <= zero_d;
      carry_q <= carry_d;
    end
  end
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
  assign result_o = out_sel_i ? c_q : s_q;
  assign reg_a_o = a_q;
  assign reg_b_o = b_q;
  assign reg_c_o = c_q;
  assign zero_o = zero_q;
  assign carry_o = carry_q;
endmodule
